ibex_register_file_sb: RTL and testbench
========================================

Name: ibex_register_file_sb

Overview:
Parametrised flip-flop register file for Ibex-class cores. Supports N read ports, up to 2 write ports, and optional same-cycle write-to-read bypass. An integrated scoreboard marks registers that have a pending write-back outstanding. Sits in ID/WB and replaces the single-write, two-read FF register file when the core runs a multi-cycle or dual-issue write-back.

Parameters:
RV32E, 0, 1: 16 words (4-bit address), 0: 32 words.
DataWidth, 32, word width in bits.
NumRead, 2, read port count (1..4).
NumWrite, 2, write port count (1..2).
BypassEn, 1, 1: a read of a register being written this cycle returns the write data.
ScoreboardCheck, 1, 1: flag writes to non-busy registers and issues to already-busy registers.
WordZeroVal, '0, reset value of every word and the constant R0 value.

Ports:
clk_i  in  1  clock.
rst_ni  in  1  reset; synchronous, active-low.
raddr_i  in  NumRead*5  read addresses, port k at [5k+:5].
rdata_o  out  NumRead*DataWidth  read data, port k at [DataWidth*k+:DataWidth].
rbusy_o  out  NumRead  port k's register has a pending write-back.
waddr_i  in  NumWrite*5  write addresses.
wdata_i  in  NumWrite*DataWidth  write data.
we_i  in  NumWrite  write strobes.
iss_valid_i  in  1  issue: mark iss_rd_i busy.
iss_rd_i  in  5  destination register of the issued instruction.
busy_cnt_o  out  6  number of busy registers.
err_o  out  1  sticky error flag.

Behaviour:
- Reset: synchronous and active-low. At any posedge with rst_ni=0, all words load WordZeroVal, all busy bits clear, busy_cnt_o=0 and err_o=0. This applies mid-operation too; any writes or issues in the same cycle are discarded.
- R0:
  - Reads always return WordZeroVal with rbusy=0.
  - Writes to R0 are dropped and are not an error.
  - Issues to R0 are dropped.
- Address width:
  - For RV32E, only addr[3:0] is decoded.
  - addr[4]=1 with we=1 or iss_valid=1 sets err_o; the write or issue is dropped.
  - addr[4]=1 on a read returns WordZeroVal.
- Write latency: data written at edge t is readable combinationally from cycle t+1.
- Bypass:
  - With BypassEn=1, a read whose address matches an active write (nonzero, in range) returns that wdata in the same cycle.
  - With BypassEn=0, the read returns the stored value.
- Write collision: both ports write the same nonzero address in one cycle → port 1 wins for storage and bypass; err_o is set.
- Scoreboard update:
  - A busy bit is cleared when any write port writes that register.
  - A busy bit is set on iss_valid_i.
  - Set and clear of the same register in one cycle → set wins, and the bit stays/becomes busy.
- rbusy_o reflects the registered busy bits and is not bypassed by a same-cycle clear.
- busy_cnt_o is registered, equals popcount(busy) after each edge, range 0..31 (0..15 for RV32E), and never wraps.
- ScoreboardCheck=1:
  - A write to a non-busy nonzero register sets err_o; the write is still performed.
  - An issue to an already-busy register (and not cleared the same cycle) sets err_o.
- ScoreboardCheck=0: the scoreboard is still maintained but its errors are masked. Range and collision errors remain.
- err_o is registered and sticky; only reset clears it.

Decomposition:
- ibex_pkg additions:
  - RegAddrW=5.
  - Function rf_num_words(RV32E).
  - Typedef rf_sb_err_e {RfErrNone, RfErrRange, RfErrCollide, RfErrSbWrite, RfErrSbIssue}, used only by assertions and coverage.
- Sub-module ibex_rf_scoreboard: holds the busy vector, the set/clear priority, busy_cnt and the scoreboard error terms.
- Top level: storage array, write decode/collision logic, and per-port read/bypass mux generated with a for-loop over NumRead.

Test Plan:
- Reset then read all addresses on all ports → WordZeroVal, rbusy_o=0, busy_cnt_o=0, err_o=0.
- Issue x5 at t0, write x5=32'hDEADBEEF on port 0 at t3 with BypassEn=1 → rdata=DEADBEEF on cycle t3; rbusy=1 on t1..t3 and 0 at t4; busy_cnt goes 1 then 0; err_o=0.
- Issue x7 and write x7 the same cycle while x7 is busy → x7 stays busy, busy_cnt unchanged, data stored, err_o=0.
- Both ports write x9 (port 0 = 1, port 1 = 2) while x9 is busy → x9 reads 2 next cycle; err_o=1 and stays 1 until reset.
- Write x3 without a prior issue, ScoreboardCheck=1 → data stored, err_o=1. Same stimulus with ScoreboardCheck=0 → err_o=0.
- RV32E=1: write address 5'h12 → no storage change, err_o=1. Then assert rst_ni=0 for one edge mid-sequence with busy_cnt=3 → all words reset, busy_cnt_o=0, err_o=0.

Source files
------------

// File: rtl/ibex_register_file_sb_pkg.sv
// Shared constants, types and helpers for the scoreboarded flip-flop register file.
package ibex_register_file_sb_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned BusyCntW = 6;

  typedef enum logic [2:0] {
    RfErrNone,
    RfErrRange,
    RfErrCollide,
    RfErrSbWrite,
    RfErrSbIssue
  } rf_sb_err_e;

  function automatic int unsigned rf_num_words(input bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

endpackage

// File: rtl/ibex_rf_scoreboard.sv
// Pending write-back tracker: busy vector, set-over-clear priority, busy count, scoreboard errors.
module ibex_rf_scoreboard
  import ibex_register_file_sb_pkg::*;
#(
  parameter int unsigned NumWords        = 32,
  parameter bit          ScoreboardCheck = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumWords-1:0] set_i,
  input  logic [NumWords-1:0] clr_i,
  output logic [NumWords-1:0] busy_o,
  output logic [BusyCntW-1:0] busy_cnt_o,
  output logic [1:0]          sb_err_c
);

  logic [NumWords-1:0] busy_d;
  logic [BusyCntW-1:0] cnt_d;

  always_comb begin
    busy_d = (busy_o & ~clr_i) | set_i;
    cnt_d  = '0;
    for (int unsigned i = 0; i < NumWords; i++) begin
      cnt_d = cnt_d + BusyCntW'(busy_d[i]);
    end
    // [0]: write-back without a pending issue, [1]: re-issue of a still-busy register
    sb_err_c    = '0;
    sb_err_c[0] = ScoreboardCheck && (|(clr_i & ~busy_o));
    sb_err_c[1] = ScoreboardCheck && (|(set_i & busy_o & ~clr_i));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_o     <= '0;
      busy_cnt_o <= '0;
    end else begin
      busy_o     <= busy_d;
      busy_cnt_o <= cnt_d;
    end
  end

endmodule

// File: rtl/ibex_register_file_sb.sv
// Flip-flop register file with N read ports, up to two write ports, bypass and write-back scoreboard.
module ibex_register_file_sb
  import ibex_register_file_sb_pkg::*;
#(
  parameter bit                    RV32E           = 1'b0,
  parameter int unsigned           DataWidth       = 32,
  parameter int unsigned           NumRead         = 2,
  parameter int unsigned           NumWrite        = 2,
  parameter bit                    BypassEn        = 1'b1,
  parameter bit                    ScoreboardCheck = 1'b1,
  parameter logic [DataWidth-1:0]  WordZeroVal     = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumRead*RegAddrW-1:0]   raddr_i,
  output logic [NumRead*DataWidth-1:0]  rdata_o,
  output logic [NumRead-1:0]            rbusy_o,
  input  logic [NumWrite*RegAddrW-1:0]  waddr_i,
  input  logic [NumWrite*DataWidth-1:0] wdata_i,
  input  logic [NumWrite-1:0]           we_i,
  input  logic                          iss_valid_i,
  input  logic [RegAddrW-1:0]           iss_rd_i,
  output logic [BusyCntW-1:0]           busy_cnt_o,
  output logic                          err_o
);

  localparam int unsigned NumWords = rf_num_words(RV32E);
  localparam int unsigned IdxW     = $clog2(NumWords);

  function automatic logic in_range(input logic [RegAddrW-1:0] a);
    return !(RV32E && a[RegAddrW-1]);
  endfunction

  logic [DataWidth-1:0]           mem [NumWords];
  logic [NumWrite-1:0]            wr_ok;
  logic [NumWrite-1:0]            wr_range_err;
  logic [NumWrite-1:0][IdxW-1:0]  widx;
  logic [NumWords-1:0]            set, clr, busy;
  logic                           iss_range_err;
  logic                           collide;
  logic [1:0]                     sb_err;
  logic                           err_set;
  rf_sb_err_e                     err_cause;

  // Write/issue decode: R0 and out-of-range addresses never reach storage or the scoreboard
  always_comb begin
    wr_ok        = '0;
    wr_range_err = '0;
    widx         = '0;
    clr          = '0;
    set          = '0;
    for (int unsigned w = 0; w < NumWrite; w++) begin
      widx[w]         = waddr_i[w*RegAddrW +: IdxW];
      wr_range_err[w] = we_i[w] && !in_range(waddr_i[w*RegAddrW +: RegAddrW]);
      wr_ok[w]        = we_i[w] && in_range(waddr_i[w*RegAddrW +: RegAddrW]) && (widx[w] != '0);
      if (wr_ok[w]) clr[widx[w]] = 1'b1;
    end
    iss_range_err = iss_valid_i && !in_range(iss_rd_i);
    if (iss_valid_i && in_range(iss_rd_i) && (iss_rd_i[IdxW-1:0] != '0)) begin
      set[iss_rd_i[IdxW-1:0]] = 1'b1;
    end
  end

  if (NumWrite > 1) begin : g_collide
    assign collide = wr_ok[0] && wr_ok[1] && (widx[0] == widx[1]);
  end else begin : g_no_collide
    assign collide = 1'b0;
  end

  // Later write ports override earlier ones on the same word
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NumWords; i++) mem[i] <= WordZeroVal;
    end else begin
      for (int unsigned w = 0; w < NumWrite; w++) begin
        if (wr_ok[w]) mem[widx[w]] <= wdata_i[w*DataWidth +: DataWidth];
      end
    end
  end

  for (genvar k = 0; k < NumRead; k++) begin : g_read
    logic [RegAddrW-1:0]  ra;
    logic [IdxW-1:0]      ri;
    logic                 hit;
    logic [DataWidth-1:0] rd;

    assign ra  = raddr_i[k*RegAddrW +: RegAddrW];
    assign ri  = ra[IdxW-1:0];
    assign hit = in_range(ra) && (ri != '0);

    always_comb begin
      rd = hit ? mem[ri] : WordZeroVal;
      if (BypassEn && hit) begin
        for (int unsigned w = 0; w < NumWrite; w++) begin
          if (wr_ok[w] && (widx[w] == ri)) rd = wdata_i[w*DataWidth +: DataWidth];
        end
      end
    end

    assign rdata_o[k*DataWidth +: DataWidth] = rd;
    assign rbusy_o[k] = hit && busy[ri];
  end

  ibex_rf_scoreboard #(
    .NumWords        (NumWords),
    .ScoreboardCheck (ScoreboardCheck)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .set_i      (set),
    .clr_i      (clr),
    .busy_o     (busy),
    .busy_cnt_o (busy_cnt_o),
    .sb_err_c   (sb_err)
  );

  assign err_set = (|wr_range_err) | iss_range_err | collide | (|sb_err);

  always_comb begin
    err_cause = RfErrNone;
    if (|sb_err[1])                          err_cause = RfErrSbIssue;
    if (|sb_err[0])                          err_cause = RfErrSbWrite;
    if (collide)                             err_cause = RfErrCollide;
    if ((|wr_range_err) || iss_range_err)    err_cause = RfErrRange;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_o <= 1'b0;
    else         err_o <= err_o | err_set;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && err_set) assert (err_cause != RfErrNone);
  end

endmodule

// File: tb/tb_ibex_register_file_sb.sv
// Scoreboard-queue bench for ibex_register_file_sb: default, unchecked and RV32E instances share stimulus.
module tb_ibex_register_file_sb;

  localparam logic [31:0] WZ = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  we;
  logic        iss_valid;
  logic [4:0]  iss_rd;

  logic [63:0] rdata_d, rdata_n, rdata_e;
  logic [1:0]  rbusy_d, rbusy_n, rbusy_e;
  logic [5:0]  cnt_d, cnt_n, cnt_e;
  logic        err_d, err_n, err_e;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ibex_register_file_sb u_dut (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_d), .rbusy_o(rbusy_d),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
    .busy_cnt_o(cnt_d), .err_o(err_d)
  );

  ibex_register_file_sb #(.ScoreboardCheck(1'b0)) u_nochk (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
    .busy_cnt_o(cnt_n), .err_o(err_n)
  );

  ibex_register_file_sb #(.RV32E(1'b1)) u_e (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata_e), .rbusy_o(rbusy_e),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .iss_valid_i(iss_valid), .iss_rd_i(iss_rd),
    .busy_cnt_o(cnt_e), .err_o(err_e)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic pop(input logic [31:0] obs);
    exp_t e;
    if (q.size() == 0) begin
      check("queue_underflow", 32'd0, 32'd1);
    end else begin
      e = q.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    we        = 2'b00;
    waddr     = '0;
    wdata     = '0;
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_valid = 1'b1;
    iss_rd    = rd;
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    raddr = '0;
    idle();
    repeat (2) tick();
    rst_n = 1'b1;

    // reset state on every address
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(a), 5'(a)};
      push("rst_rd0", WZ); push("rst_rd1", WZ); push("rst_rbusy", 32'd0); push("rst_rd_e", WZ);
      #1;
      pop(rdata_d[31:0]); pop(rdata_d[63:32]); pop(32'(rbusy_d)); pop(rdata_e[31:0]);
    end
    push("rst_cnt", 32'd0); push("rst_err", 32'd0);
    pop(32'(cnt_d)); pop(32'(err_d));

    // R0: write and issue dropped, no error
    we = 2'b01; waddr = 10'd0; wdata = 64'h55; iss_valid = 1'b1; iss_rd = 5'd0; raddr = 10'd0;
    push("r0_bypass", WZ);
    #1; pop(rdata_d[31:0]);
    tick(); idle();
    push("r0_rd", WZ); push("r0_cnt", 32'd0); push("r0_err", 32'd0);
    pop(rdata_d[31:0]); pop(32'(cnt_d)); pop(32'(err_d));

    // issue x5, write-back three cycles later with bypass
    raddr = {5'd0, 5'd5};
    issue(5'd5);
    push("x5_busy_t1", 32'd1); push("x5_cnt_t1", 32'd1);
    pop(32'(rbusy_d[0])); pop(32'(cnt_d));
    tick();
    push("x5_busy_t2", 32'd1); pop(32'(rbusy_d[0]));
    tick();
    we = 2'b01; waddr = {5'd0, 5'd5}; wdata = {32'd0, 32'hDEADBEEF};
    push("x5_bypass", 32'hDEADBEEF); push("x5_busy_t3", 32'd1);
    #1; pop(rdata_d[31:0]); pop(32'(rbusy_d[0]));
    tick(); idle();
    push("x5_busy_t4", 32'd0); push("x5_cnt_t4", 32'd0); push("x5_rd", 32'hDEADBEEF);
    push("x5_err", 32'd0); push("x5_err_e", 32'd0);
    pop(32'(rbusy_d[0])); pop(32'(cnt_d)); pop(rdata_d[31:0]); pop(32'(err_d)); pop(32'(err_e));

    // issue and write x7 in the same cycle while busy: set wins
    issue(5'd7);
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'h77};
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick(); idle();
    raddr = {5'd0, 5'd7};
    push("x7_busy", 32'd1); push("x7_cnt", 32'd1); push("x7_rd", 32'h77); push("x7_err", 32'd0);
    #1;
    pop(32'(rbusy_d[0])); pop(32'(cnt_d)); pop(rdata_d[31:0]); pop(32'(err_d));

    // both ports write busy x9: port 1 wins, collision error is sticky
    issue(5'd9);
    raddr = {5'd0, 5'd9};
    we = 2'b11; waddr = {5'd9, 5'd9}; wdata = {32'd2, 32'd1};
    push("x9_bypass", 32'd2);
    #1; pop(rdata_d[31:0]);
    tick(); idle();
    push("x9_rd", 32'd2); push("x9_err", 32'd1); push("x9_cnt", 32'd1); push("x9_busy", 32'd0);
    pop(rdata_d[31:0]); pop(32'(err_d)); pop(32'(cnt_d)); pop(32'(rbusy_d[0]));
    push("x9_nochk_err", 32'd1); pop(32'(err_n));
    repeat (2) tick();
    push("x9_err_sticky", 32'd1); pop(32'(err_d));
    do_reset();
    push("rst2_err", 32'd0); push("rst2_cnt", 32'd0); push("rst2_x9", WZ);
    pop(32'(err_d)); pop(32'(cnt_d)); pop(rdata_d[31:0]);

    // write x3 without an issue: checked vs unchecked
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'h33};
    tick(); idle();
    raddr = {5'd0, 5'd3};
    #1;
    push("x3_rd", 32'h33); push("x3_err", 32'd1); push("x3_rd_nochk", 32'h33); push("x3_err_nochk", 32'd0);
    pop(rdata_d[31:0]); pop(32'(err_d)); pop(rdata_n[31:0]); pop(32'(err_n));
    do_reset();

    // double issue of x6
    issue(5'd6);
    issue(5'd6);
    push("x6_err", 32'd1); push("x6_err_nochk", 32'd0); push("x6_cnt", 32'd1);
    pop(32'(err_d)); pop(32'(err_n)); pop(32'(cnt_d));
    do_reset();

    // RV32E: out-of-range write dropped, then mid-sequence reset
    issue(5'd2);
    we = 2'b01; waddr = {5'd0, 5'd2}; wdata = {32'd0, 32'h22};
    tick(); idle();
    push("e_x2_err", 32'd0); pop(32'(err_e));
    we = 2'b01; waddr = {5'd0, 5'h12}; wdata = {32'd0, 32'hAA};
    tick(); idle();
    raddr = {5'h12, 5'd2};
    #1;
    push("e_x2_kept", 32'h22); push("e_hi_rd", WZ); push("e_range_err", 32'd1);
    pop(rdata_e[31:0]); pop(rdata_e[63:32]); pop(32'(err_e));
    issue(5'd10);
    issue(5'd11);
    issue(5'd12);
    push("e_cnt3", 32'd3); pop(32'(cnt_e));
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'd0, 32'h44}; iss_valid = 1'b1; iss_rd = 5'd4;
    do_reset();
    raddr = {5'd4, 5'd2};
    #1;
    push("e_rst_cnt", 32'd0); push("e_rst_err", 32'd0); push("e_rst_x2", WZ);
    push("e_rst_x4", WZ); push("e_rst_x4_busy", 32'd0);
    pop(32'(cnt_e)); pop(32'(err_e)); pop(rdata_e[31:0]); pop(rdata_e[63:32]); pop(32'(rbusy_e[1]));

    if (q.size() != 0) check("queue_leftover", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
